// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: the op encoding and an
// elaboration-time clog2 used to size the shift-amount path.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_ROR = 2'b10,
    SH_SRA = 2'b11
  } sh_op_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One fixed-distance shift level: either shifts its input by DIST in the
// requested mode or passes data and carry through untouched.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic             en,
  input  sh_op_t           op,
  input  logic             sign,
  input  logic [WIDTH-1:0] x,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> DIST);

  // Shift by DIST when enabled; ROR leaves carry alone, the stage derives it from the MSB.
  always_comb begin
    y    = x;
    cout = cin;
    if (en) begin
      case (op)
        SH_SLL: begin
          y    = x << DIST;
          cout = x[WIDTH-DIST];
        end
        SH_SRL: begin
          y    = x >> DIST;
          cout = x[DIST-1];
        end
        SH_SRA: begin
          y    = (x >> DIST) | (sign ? FILL_MASK : {WIDTH{1'b0}});
          cout = x[DIST-1];
        end
        SH_ROR: begin
          y    = (x >> DIST) | (x << (WIDTH - DIST));
          cout = cin;
        end
        default: begin
          y    = x;
          cout = cin;
        end
      endcase
    end else begin
      y    = x;
      cout = cin;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SHW shift levels grouped LEVELS_PER_STAGE per
// register stage, with a combinational valid/ready chain across the stages.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4,
  localparam int SHW    = clog2(WIDTH),
  localparam int NSTAGE = (SHW + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             valid;
    sh_op_t           op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             sign;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [NSTAGE-1:0] valid_s;
  logic [NSTAGE-1:0] ready_s;
  logic              zero_r;
  logic              unused_s;

  // Stage i can load when it is empty or anything downstream of it can move.
  always_comb begin
    logic room;
    ready_s = {NSTAGE{1'b0}};
    room    = out_ready;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      room       = room | ~valid_s[i];
      ready_s[i] = room;
    end
  end

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    localparam int FIRST_LVL = s * LEVELS_PER_STAGE;
    localparam int NLVL = (FIRST_LVL + LEVELS_PER_STAGE <= SHW) ? LEVELS_PER_STAGE
                                                                : SHW - FIRST_LVL;
    stage_t head_s;
    stage_t nxt_s;
    stage_t q_r;

    if (s == 0) begin : g_src_in
      assign head_s = '{valid: in_valid, op: sh_op_t'(in_op), shamt: in_shamt,
                        data: in_data, carry: 1'b0, sign: in_data[WIDTH-1], tag: in_tag};
    end else begin : g_src_prev
      assign head_s = g_stage[s-1].q_r;
    end

    // Largest distances first: level LVL consumes shamt bit SHW-1-LVL.
    for (genvar k = 0; k < NLVL; k++) begin : g_lvl
      localparam int LVL = FIRST_LVL + k;
      localparam int BIT = SHW - 1 - LVL;
      logic [WIDTH-1:0] x_s;
      logic [WIDTH-1:0] y_s;
      logic             cin_s;
      logic             cout_s;

      if (k == 0) begin : g_head
        assign x_s   = head_s.data;
        assign cin_s = head_s.carry;
      end else begin : g_link
        assign x_s   = g_lvl[k-1].y_s;
        assign cin_s = g_lvl[k-1].cout_s;
      end

      shift_level #(.WIDTH(WIDTH), .DIST(1 << BIT)) u_level (
        .en   (head_s.shamt[BIT]),
        .op   (head_s.op),
        .sign (head_s.sign),
        .x    (x_s),
        .cin  (cin_s),
        .y    (y_s),
        .cout (cout_s)
      );
    end

    // Next stage contents; a rotate's carry always mirrors the current MSB.
    always_comb begin
      nxt_s      = head_s;
      nxt_s.data = g_lvl[NLVL-1].y_s;
      if (head_s.op == SH_ROR) begin
        nxt_s.carry = g_lvl[NLVL-1].y_s[WIDTH-1];
      end else begin
        nxt_s.carry = g_lvl[NLVL-1].cout_s;
      end
    end

    // Stage register: loads whenever the ready chain says the slot can move.
    always_ff @(posedge clk) begin
      if (reset) begin
        q_r <= '0;
      end else if (ready_s[s]) begin
        q_r <= nxt_s;
      end
    end

    assign valid_s[s] = q_r.valid;
  end

  // Zero flag is registered alongside the final stage's data.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_r <= 1'b0;
    end else if (ready_s[NSTAGE-1]) begin
      zero_r <= (g_stage[NSTAGE-1].nxt_s.data == {WIDTH{1'b0}});
    end
  end

  assign in_ready  = ready_s[0];
  assign out_valid = g_stage[NSTAGE-1].q_r.valid;
  assign out_data  = g_stage[NSTAGE-1].q_r.data;
  assign out_carry = g_stage[NSTAGE-1].q_r.carry;
  assign out_tag   = g_stage[NSTAGE-1].q_r.tag;
  assign out_zero  = zero_r;

  assign unused_s = ^{g_stage[NSTAGE-1].q_r.op, g_stage[NSTAGE-1].q_r.shamt,
                      g_stage[NSTAGE-1].q_r.sign};

endmodule
